// File: rtl/memory_fifo_unit.sv
// ---------------------------------------------------------------------------
// memory_fifo_unit
//
// Synchronous single-clock FIFO that replaces the old single-word 35-bit
// write-enabled storage register. It holds DEPTH words of WIDTH bits in
// first-in/first-out order. It has independent write and read enables,
// registered occupancy status, and one-cycle error pulses for rejected
// requests.
//
// Read data is registered, and there is no fall-through path. A word
// written at edge N can be popped at edge N+1 at the earliest, and it
// appears on dout after that edge.
//
// When the FIFO is full, a write is still accepted if a read is accepted
// on the same edge. The head word leaves and the freed slot is refilled in
// one cycle. When the FIFO is empty, a simultaneous read is rejected and
// the write is accepted.
//
// Ports
//   clk        rising-edge clock
//   arst       asynchronous active-high reset
//   wren       write request; din is stored at the clk edge if accepted
//   din        write data, WIDTH bits
//   rden       read request; the head word is popped if accepted
//   dout       registered read data; holds its value when no read occurs
//   valid      one-cycle pulse: dout was loaded by the last accepted read
//   full       count == DEPTH
//   empty      count == 0
//   count      occupancy, 0..DEPTH, AW+1 bits
//   overflow   one-cycle pulse: a write was rejected
//   underflow  one-cycle pulse: a read was rejected
//
// Every output is driven directly from a flop. No input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module memory_fifo_unit #(
  parameter  int WIDTH = 35,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             wren,
  input  logic [WIDTH-1:0] din,
  input  logic             rden,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  // count is one bit wider than the pointers so that it can represent
  // DEPTH itself.
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  // Storage and pointers. DEPTH is a power of two, so the pointers wrap
  // modulo DEPTH simply by overflowing their AW bits.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Accept decisions, made on the registered state before the edge.
  logic             rd_acc;
  logic             wr_acc;
  logic [AW:0]      count_nxt;

  // A write into a full FIFO is legal only when the same edge frees a slot
  // through an accepted read.
  // NOTE: every signal assigned in always_comb gets a default value first,
  // so that no path can leave it unassigned and infer a latch.
  always_comb begin
    rd_acc    = 1'b0;
    wr_acc    = 1'b0;
    count_nxt = count;
    rd_acc    = rden & ~empty;
    wr_acc    = wren & (~full | rd_acc);
    count_nxt = count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
  end

  // Storage array. It is deliberately kept out of the reset domain, so it
  // can map onto plain RAM or flops without a reset network. Its contents
  // are meaningless until written, and the pointers guarantee that a word
  // is never read before it has been written.
  // NOTE: memories are not reset; only the control state that decides what
  // is readable returns to a known value.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  // Control state and registered outputs. full and empty are derived from
  // count_nxt, so they always agree with the count they accompany.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      valid     <= rd_acc;
      count     <= count_nxt;
      full      <= (count_nxt == FULL_COUNT);
      empty     <= (count_nxt == '0);
      overflow  <= wren & ~wr_acc;
      underflow <= rden & ~rd_acc;
    end
  end

endmodule

// File: tb/tb_memory_fifo_unit.sv
// ---------------------------------------------------------------------------
// tb_memory_fifo_unit
//
// Bench for memory_fifo_unit, built with WIDTH=35 and DEPTH=4.
//   1. A table of single-cycle vectors with hand-derived expectations:
//      reset/idle, fill/overflow, drain/underflow, simultaneous at full,
//      and simultaneous at empty.
//   2. Hand-written sequences for wrap-around and for reset mid-operation.
//   3. Randomised traffic compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_memory_fifo_unit;

  localparam int W  = 35;
  localparam int D  = 4;
  localparam int AW = $clog2(D);

  logic          clk = 1'b0;
  logic          arst;
  logic          wren;
  logic [W-1:0]  din;
  logic          rden;
  logic [W-1:0]  dout;
  logic          valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  memory_fifo_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .arst      (arst),
    .wren      (wren),
    .din       (din),
    .rden      (rden),
    .dout      (dout),
    .valid     (valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // One table entry: the inputs applied for one clock edge, and the outputs
  // expected just after that edge.
  typedef struct {
    logic         w;
    logic         r;
    logic [W-1:0] d;
    logic [W-1:0] e_dout;
    logic         e_valid;
    int           e_count;
    logic         e_full;
    logic         e_empty;
    logic         e_ovf;
    logic         e_unf;
  } vec_t;

  vec_t vecs[$];

  // Queue-based reference model of the FIFO contents and outputs.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout;
  logic         m_valid;
  logic         m_ovf;
  logic         m_unf;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] e_dout,
                            input logic e_valid, input int e_count,
                            input logic e_full, input logic e_empty,
                            input logic e_ovf, input logic e_unf);
    check({tag, ".dout"},      64'(dout),      64'(e_dout));
    check({tag, ".valid"},     64'(valid),     64'(e_valid));
    check({tag, ".count"},     64'(count),     64'(e_count));
    check({tag, ".full"},      64'(full),      64'(e_full));
    check({tag, ".empty"},     64'(empty),     64'(e_empty));
    check({tag, ".overflow"},  64'(overflow),  64'(e_ovf));
    check({tag, ".underflow"}, 64'(underflow), 64'(e_unf));
  endtask

  // Applies one cycle of inputs, then returns 1 time unit after the edge
  // with the inputs dropped back to idle.
  task automatic step(input logic w, input logic r, input logic [W-1:0] d);
    wren = w;
    rden = r;
    din  = d;
    @(posedge clk);
    #1;
    wren = 1'b0;
    rden = 1'b0;
  endtask

  task automatic add_vec(input logic w, input logic r, input logic [W-1:0] d,
                         input logic [W-1:0] e_dout, input logic e_valid,
                         input int e_count, input logic e_full,
                         input logic e_empty, input logic e_ovf,
                         input logic e_unf);
    vec_t v;
    v.w = w; v.r = r; v.d = d;
    v.e_dout = e_dout; v.e_valid = e_valid; v.e_count = e_count;
    v.e_full = e_full; v.e_empty = e_empty; v.e_ovf = e_ovf; v.e_unf = e_unf;
    vecs.push_back(v);
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // Behavioural rules: a read succeeds when something is stored. A write
  // succeeds when there is room, or when the same edge's read makes room.
  task automatic model_step(input logic w, input logic r, input logic [W-1:0] d);
    bit ra, wa;
    ra = r && (mq.size() > 0);
    wa = w && ((mq.size() < D) || ra);
    if (ra) m_dout = mq.pop_front();
    if (wa) mq.push_back(d);
    m_valid = ra;
    m_ovf   = w && !wa;
    m_unf   = r && !ra;
  endtask

  // Stops the run if the bench itself ever stalls.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [W-1:0] PAT = 35'b00000001111111000000011111110000000;

  initial begin
    logic [63:0] rnd;
    arst = 1'b1;
    wren = 1'b0;
    rden = 1'b0;
    din  = '0;

    // ---------------- vector table ----------------
    // Reset/idle: a read while empty only raises underflow.
    add_vec(0, 1, '0,            '0, 0, 0, 0, 1, 0, 1);
    add_vec(0, 0, '0,            '0, 0, 0, 0, 1, 0, 0);
    // Fill, then one rejected write.
    add_vec(1, 0, 35'h1,         '0, 0, 1, 0, 0, 0, 0);
    add_vec(1, 0, 35'h2,         '0, 0, 2, 0, 0, 0, 0);
    add_vec(1, 0, 35'h3,         '0, 0, 3, 0, 0, 0, 0);
    add_vec(1, 0, 35'h4,         '0, 0, 4, 1, 0, 0, 0);
    add_vec(1, 0, 35'h7FFFFFFFF, '0, 0, 4, 1, 0, 1, 0);
    add_vec(0, 0, '0,            '0, 0, 4, 1, 0, 0, 0);
    // Drain in order, then one rejected read; dout holds the last word.
    add_vec(0, 1, '0, 35'h1, 1, 3, 0, 0, 0, 0);
    add_vec(0, 1, '0, 35'h2, 1, 2, 0, 0, 0, 0);
    add_vec(0, 1, '0, 35'h3, 1, 1, 0, 0, 0, 0);
    add_vec(0, 1, '0, 35'h4, 1, 0, 0, 1, 0, 0);
    add_vec(0, 1, '0, 35'h4, 0, 0, 0, 1, 0, 1);
    // Refill, then a simultaneous write and read while full.
    add_vec(1, 0, 35'h1,  35'h4, 0, 1, 0, 0, 0, 0);
    add_vec(1, 0, 35'h2,  35'h4, 0, 2, 0, 0, 0, 0);
    add_vec(1, 0, 35'h3,  35'h4, 0, 3, 0, 0, 0, 0);
    add_vec(1, 0, 35'h4,  35'h4, 0, 4, 1, 0, 0, 0);
    add_vec(1, 1, 35'hAA, 35'h1, 1, 4, 1, 0, 0, 0);
    add_vec(0, 1, '0,     35'h2, 1, 3, 0, 0, 0, 0);
    add_vec(0, 1, '0,     35'h3, 1, 2, 0, 0, 0, 0);
    add_vec(0, 1, '0,     35'h4, 1, 1, 0, 0, 0, 0);
    add_vec(0, 1, '0,     35'hAA, 1, 0, 0, 1, 0, 0);
    // Simultaneous write and read while empty: the read is rejected and
    // the write is accepted.
    add_vec(1, 1, 35'h33, 35'hAA, 0, 1, 0, 0, 0, 1);
    add_vec(0, 1, '0,     35'h33, 1, 0, 0, 1, 0, 0);

    #100;
    arst = 1'b0;
    #1;
    check_outs("reset", '0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].w, vecs[i].r, vecs[i].d);
      check_outs($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_valid,
                 vecs[i].e_count, vecs[i].e_full, vecs[i].e_empty,
                 vecs[i].e_ovf, vecs[i].e_unf);
    end

    // ---------------- wrap-around: 10 write/read pairs ----------------
    for (int i = 0; i < 10; i++) begin
      step(1, 0, PAT ^ W'(i));
      check($sformatf("wrap%0d.count_w", i), 64'(count), 64'd1);
      step(0, 1, '0);
      check($sformatf("wrap%0d.dout", i),    64'(dout),  64'(PAT ^ W'(i)));
      check($sformatf("wrap%0d.valid", i),   64'(valid), 64'd1);
      check($sformatf("wrap%0d.count_r", i), 64'(count), 64'd0);
    end

    // ---------------- reset mid-operation ----------------
    step(1, 0, 35'h11);
    step(1, 0, 35'h22);
    step(1, 0, 35'h33);
    step(1, 0, 35'h44);
    step(0, 1, '0);
    check("midrst.pre_count", 64'(count), 64'd3);
    check("midrst.pre_valid", 64'(valid), 64'd1);
    #3;                       // between clock edges
    arst = 1'b1;
    #1;
    check_outs("midrst.async", '0, 0, 0, 0, 1, 0, 0);
    #12;
    arst = 1'b0;
    step(0, 1, '0);
    check_outs("midrst.rd_empty", '0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 35'h55);
    step(0, 1, '0);
    check_outs("midrst.rd55", 35'h55, 1, 0, 0, 1, 0, 0);

    // ---------------- randomised traffic vs reference model ----------------
    arst = 1'b1;
    #7;
    arst = 1'b0;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      logic w, r;
      // Bias the traffic in phases so the FIFO spends time both near full
      // and near empty.
      if ((i / 50) % 2 == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      rnd = {$urandom, $urandom};
      step(w, r, rnd[W-1:0]);
      model_step(w, r, rnd[W-1:0]);
      check_outs($sformatf("rnd%0d", i), m_dout, m_valid, mq.size(),
                 mq.size() == D, mq.size() == 0, m_ovf, m_unf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
